// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a simple-dual-port RAM: sub-word loads with extension, sub-word stores via RMW.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned/size=3 requests answer with resp_err instead of touching RAM.
module mem_access_ctrl #(
  parameter int DATAW    = 32,
  parameter int ADDRW    = 32,
  parameter int WORD_LEN = 2,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [DATAW-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [DATAW-1:0] resp_rdata,
  output logic             resp_err,
  output logic             ram_wea,
  output logic [ADDRW-1:0] ram_addra,
  output logic [DATAW-1:0] ram_dina,
  output logic [ADDRW-1:0] ram_addrb,
  input  logic [DATAW-1:0] ram_doutb
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             we_q, we_nxt;
  logic [1:0]       size_q, size_nxt;
  logic             uns_q, uns_nxt;
  logic [1:0]       off_q, off_nxt;
  logic [DATAW-1:0] wdata_q, wdata_nxt;
  logic             resp_valid_nxt, resp_err_nxt, ram_wea_nxt;
  logic [DATAW-1:0] resp_rdata_nxt, ram_dina_nxt;
  logic [ADDRW-1:0] ram_addra_nxt, ram_addrb_nxt;

  logic [1:0]       eff_size, eff_off;
  logic [ADDRW-1:0] word_addr;

  function automatic logic [DATAW-1:0] extract(input logic [DATAW-1:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [DATAW-1:0]   sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'd0:    extract = uns ? {{(DATAW-8){1'b0}}, b}  : {{(DATAW-8){b[7]}}, b};
      2'd1:    extract = uns ? {{(DATAW-16){1'b0}}, h} : {{(DATAW-16){h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [DATAW-1:0] merge(input logic [DATAW-1:0] word, input logic [DATAW-1:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [DATAW-1:0] mask;
    mask  = ((size == 2'd0) ? DATAW'(8'hFF) : DATAW'(16'hFFFF)) << {off, 3'b000};
    merge = (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
  endfunction

  // Request decode: offsets are forced to natural alignment, size=3 behaves as word
  assign eff_size  = (req_size == 2'd3) ? 2'd2 : req_size;
  assign eff_off   = (eff_size == 2'd0) ? req_addr[1:0] :
                     (eff_size == 2'd1) ? {req_addr[1], 1'b0} : 2'b00;
  assign word_addr = {req_addr[ADDRW-1:WORD_LEN], {WORD_LEN{1'b0}}};
  assign req_ready = (state == IDLE) && rstn;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (req_size == 2'd3) ||
                    ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    we_nxt         = we_q;
    size_nxt       = size_q;
    uns_nxt        = uns_q;
    off_nxt        = off_q;
    wdata_nxt      = wdata_q;
    resp_valid_nxt = resp_valid;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    ram_wea_nxt    = 1'b0;
    ram_addra_nxt  = ram_addra;
    ram_dina_nxt   = ram_dina;
    ram_addrb_nxt  = ram_addrb;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_nxt    = req_we;
          size_nxt  = eff_size;
          uns_nxt   = req_unsigned;
          off_nxt   = eff_off;
          wdata_nxt = req_wdata;
          cnt_nxt   = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (misalign) begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = '0;
            state_nxt      = RESP;
          end else
`endif
          if (req_we && (eff_size == 2'd2)) begin
            ram_wea_nxt   = 1'b1;
            ram_addra_nxt = word_addr;
            ram_dina_nxt  = req_wdata;
            state_nxt     = WR;
          end else begin
            ram_addrb_nxt = word_addr;
            ram_addra_nxt = word_addr;
            state_nxt     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // ram_doutb is valid after READ_LAT edges; it is captured on the following edge
        if (cnt == CNT_W'(READ_LAT)) begin
          if (we_q) begin
            ram_wea_nxt  = 1'b1;
            ram_dina_nxt = merge(ram_doutb, wdata_q, size_q, off_q);
            state_nxt    = WR;
          end else begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b0;
            resp_rdata_nxt = extract(ram_doutb, size_q, off_q, uns_q);
            state_nxt      = RESP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WR: begin
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
        state_nxt      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_wea    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      ram_addrb  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      we_q       <= we_nxt;
      size_q     <= size_nxt;
      uns_q      <= uns_nxt;
      off_q      <= off_nxt;
      wdata_q    <= wdata_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      ram_wea    <= ram_wea_nxt;
      ram_addra  <= ram_addra_nxt;
      ram_dina   <= ram_dina_nxt;
      ram_addrb  <= ram_addrb_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model with read latency, byte-addressed reference memory, directed plus random requests.
module tb_mem_access_ctrl;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_wea;
  logic [31:0] ram_addra, ram_dina, ram_addrb, ram_doutb;

  mem_access_ctrl #(.DATAW(32), .ADDRW(32), .WORD_LEN(2), .READ_LAT(RL)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // RAM model: 256 words, registered read address pipeline of RL stages
  logic [31:0] ram [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] rpipe [RL];

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_wea) ram[ram_addra[9:2]] <= ram_dina;
    rpipe[0] <= ram_addrb;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_doutb = ram[rpipe[RL-1][9:2]];

  int unsigned wr_total = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  always @(posedge clk) begin
    if (ram_wea) begin
      wr_total <= wr_total + 1;
      last_wa  <= ram_addra;
      last_wd  <= ram_dina;
    end
  end

  logic [7:0]  mdl [1024];
  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input string tag);
    int          n, lat, k;
    logic [31:0] a, v, exp_rdata, exp_wa, exp_wd, held, wr0;
    logic        exp_err, trap;
    int          exp_lat, exp_w;
    trap = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`endif
    n = (size == 2'd3) ? 4 : (1 << size);
    a = (addr & ~(32'(n) - 1)) & 32'h3FF;
    exp_rdata = '0; exp_err = 1'b0; exp_w = 0; exp_wa = '0; exp_wd = '0;
    if (trap) begin
      exp_err = 1'b1; exp_lat = 1;
    end else if (!we) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(mdl[a + i]) << (8 * i);
      if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
      exp_rdata = v; exp_lat = RL + 2;
    end else begin
      for (int i = 0; i < n; i++) mdl[a + i] = 8'(wdata >> (8 * i));
      exp_wa = a & ~32'h3;
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = mdl[exp_wa + i];
      exp_w = 1; exp_lat = (n == 4) ? 2 : RL + 3;
    end

    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    wr0 = wr_total;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 30);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    held = resp_rdata;
    if (hold > 0) begin
      req_we = 1'b1; req_size = 2'd2; req_addr = 32'h3FC; req_wdata = $urandom; req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".hold_rdata"}, resp_rdata, held);
        check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
    check({tag, ".writes"}, wr_total - wr0, 32'(exp_w));
    if (exp_w == 1) begin
      check({tag, ".waddr"}, last_wa, exp_wa);
      check({tag, ".wdata"}, last_wd, exp_wd);
    end
    last_rdata = held;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w, wr0, addrb0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = w;
      for (int b = 0; b < 4; b++) mdl[4*i + b] = w[8*b +: 8];
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;

    @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.ram_wea", 32'(ram_wea), 32'd0);
    check("rst.ram_addra", ram_addra, 32'd0);
    check("rst.ram_addrb", ram_addrb, 32'd0);
    rstn = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, "sw100");
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, "lw100");
    check("lw100.const", last_rdata, 32'hDEADBEEF);

    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 0, "sw20");
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 0, "lb23");
    check("lb23.const", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 0, "lbu23");
    check("lbu23.const", last_rdata, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, "lh22");
    check("lh22.const", last_rdata, 32'hFFFF80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 0, "lhu20");
    check("lhu20.const", last_rdata, 32'h00007F01);

    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, "sw20b");
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 0, "sb21");
    check("sb21.merged", last_wd, 32'h1122AA44);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "lw20");
    check("lw20.const", last_rdata, 32'h1122AA44);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5, "hold");
    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0, "after_hold");

    addrb0 = ram_addrb;
    do_req(1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 0, "lh31");
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("lh31.addrb", ram_addrb, addrb0);
`else
    check("lh31.addrb", ram_addrb, 32'h30);
`endif

    // sb aborted by reset while waiting for read data: memory must stay untouched
    @(negedge clk);
    wr0 = wr_total;
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h22; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort.req_ready", 32'(req_ready), 32'd0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.ram_wea", 32'(ram_wea), 32'd0);
    check("abort.ram_addrb", ram_addrb, 32'd0);
    check("abort.ram_dina", ram_dina, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort.ready_after", 32'(req_ready), 32'd1);
    check("abort.no_write", wr_total - wr0, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "abort.lw20");
    check("abort.lw20.const", last_rdata, 32'h1122AA44);

    for (int t = 0; t < 60; t++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom, ($urandom_range(0, 7) == 0) ? 2 : 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store controller sitting directly upstream of the core's simple-dual-port data RAM; the RAM has one write port (A) and one read port (B).
- Accepts one pipeline memory request at a time via valid/ready and drives the RAM's single-bit write enable, write address/data and read address. Read data is captured after the RAM's fixed read latency.
- Performs little-endian byte/halfword extraction with sign/zero extension.
- Implements sub-word stores as read-modify-write, because the RAM has no byte enables.

Parameters:
- DATAW, 32, data word width (must be 32).
- ADDRW, 32, byte-address width.
- WORD_LEN, 2, log2 bytes per word; low address bits dropped by the RAM.
- READ_LAT, 1, clock edges from ram_addrb valid to ram_doutb valid (1..4).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- req_unsigned  in  1  zero-extend loads when 1.
- req_addr  in  ADDRW  byte address.
- req_wdata  in  DATAW  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATAW  extended load data; 0 for stores.
- resp_err  out  1  misaligned access (feature-dependent).
- ram_wea  out  1  RAM write enable.
- ram_addra  out  ADDRW  RAM write byte address, low WORD_LEN bits 0.
- ram_dina  out  DATAW  RAM write data.
- ram_addrb  out  ADDRW  RAM read byte address, low WORD_LEN bits 0.
- ram_doutb  in  DATAW  RAM read data.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rstn. All state and all RAM-side outputs are registered.
- Reset values (while rstn=0): state IDLE; req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, ram_wea=0, ram_addra=0, ram_dina=0, ram_addrb=0.
- Reset mid-operation aborts the access. A write is cancelled if ram_wea has not yet seen an edge.
- req_ready = (state==IDLE) && rstn. A request is accepted on the edge where req_valid && req_ready; all request fields are latched on that edge.
- States and transitions:
  - IDLE to RD_WAIT: load, or sub-word store.
  - IDLE to WR: word store.
  - RD_WAIT: counts READ_LAT edges, then captures ram_doutb. A load goes to RESP; a sub-word store goes to WR with merged data.
  - WR: ram_wea=1 for exactly one cycle, then RESP.
  - RESP to IDLE: on resp_valid && resp_ready.
- Latency, counting edges after the accept edge E0:
  - Load: ram_addrb valid after E0; resp_valid rises after E(READ_LAT+1).
  - Word store: ram_wea high between E0 and E1; resp_valid after E1.
  - Sub-word store: ram_wea high after E(READ_LAT+1); resp_valid after E(READ_LAT+2).
- Response hold: resp_valid, resp_rdata and resp_err stay stable until accepted. There is no new accept before the response handshake, so the earliest next accept is the cycle after it.
- Lane selection (little-endian): byte lane = addr[1:0]; half lane = addr[1].
  - Load extraction shifts the lane to bit 0, then sign-extends from bit 7/15, or zero-extends if req_unsigned.
  - RMW merge replaces only the selected lane with req_wdata[7:0] or [15:0]. Other lanes keep the read value.
- Alignment: a half access is misaligned when addr[0]=1; a word access is misaligned when addr[1:0]!=0; size=3 is invalid.
- ram_addra/ram_addrb = {req_addr[ADDRW-1:WORD_LEN], WORD_LEN'b0}. Addresses wrap naturally at 2^ADDRW; no bounds check.
- ram_wea is never asserted outside WR. ram_addrb is held stable throughout RD_WAIT.

Optional Feature:
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - A misaligned or size=3 request goes IDLE to RESP directly; no RAM access, no ram_wea.
  - Response: resp_err=1, resp_rdata=0, resp_valid after E0.
- Undefined:
  - resp_err is tied 0.
  - Misaligned addresses have their offset bits forced down to the access's natural alignment (half: addr[0]=0; word: addr[1:0]=0), and size=3 is treated as word.

Test Plan:
- Word store 0xDEADBEEF at 0x100, then lw 0x100, READ_LAT=1 -> ram_wea one cycle with addra=0x100; response 0xDEADBEEF exactly 2 edges after load accept.
- Memory word 0x80FF7F01 at 0x20: lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
- sb 0xAA to 0x21 over 0x11223344 -> single RMW write 0x1122AA44; word read-back matches.
- resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0; next request is accepted only after the response handshake.
- lh 0x31 with trap enabled -> resp_err=1, ram_wea and ram_addrb untouched. Without trap -> reads 0x30, resp_err=0.
- rstn pulsed low during RD_WAIT of an sb -> all outputs 0 immediately, no write issued; after release req_ready=1 and a lw returns the unmodified word.
